// File: rtl/ttl_gate_array.sv
// Bank of clocked logic gates, each with an inertial glitch filter followed by a
// transport delay line; everything advances only on ce-qualified edges.
module ttl_gate_array #(
  parameter int CHANNELS = 4,
  parameter int INPUTS   = 2,
  parameter int FUNC     = 0,
  parameter int FILTER   = 0,
  parameter int DELAY    = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ce,
  input  logic [CHANNELS*INPUTS-1:0]   a,
  output logic [CHANNELS-1:0]          y,
  output logic [CHANNELS-1:0]          chg
);

  localparam int            CW      = (FILTER < 1) ? 1 : $clog2(FILTER + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(FILTER);
  // Output of the selected function when every input is low.
  localparam logic          RST_VAL = (FUNC == 0) || (FUNC == 2) || (FUNC == 5);

  generate
    if (FUNC < 0 || FUNC > 5 || CHANNELS < 1 || INPUTS < 1 || INPUTS > 8 ||
        FILTER < 0 || FILTER > 15 || DELAY < 0 || DELAY > 15) begin : g_bad_param
      $error("ttl_gate_array: parameter out of range");
    end
  endgenerate

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [INPUTS-1:0] w_in;
    logic              w_f;
    logic              w_filt_nxt;
    logic [CW-1:0]     w_cnt_nxt;
    logic              w_y;
    logic              w_y_nxt;
    logic              r_filt;
    logic [CW-1:0]     r_cnt;
    logic              r_chg;

    assign w_in = a[c*INPUTS +: INPUTS];

    always_comb begin
      case (FUNC)
        0:       w_f = ~(|w_in);
        1:       w_f = |w_in;
        2:       w_f = ~(&w_in);
        3:       w_f = &w_in;
        4:       w_f = ^w_in;
        5:       w_f = ~(^w_in);
        default: w_f = 1'b0;
      endcase
    end

    // A differing value must be seen FILTER+1 enabled edges in a row before it is taken.
    always_comb begin
      w_filt_nxt = r_filt;
      w_cnt_nxt  = '0;
      if (w_f != r_filt) begin
        if (r_cnt == CNT_MAX) begin
          w_filt_nxt = w_f;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
    end

    if (DELAY == 0) begin : g_nodly
      assign w_y     = r_filt;
      assign w_y_nxt = w_filt_nxt;
    end else begin : g_dly
      logic [DELAY-1:0] r_dly;
      logic [DELAY-1:0] w_dly_nxt;

      assign w_dly_nxt = DELAY'({r_dly, r_filt});
      assign w_y       = r_dly[DELAY-1];
      assign w_y_nxt   = w_dly_nxt[DELAY-1];

      always_ff @(posedge clk) begin
        if (reset) begin
          r_dly <= {DELAY{RST_VAL}};
        end else if (ce) begin
          r_dly <= w_dly_nxt;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        r_filt <= RST_VAL;
        r_cnt  <= '0;
        r_chg  <= 1'b0;
      end else begin
        if (ce) begin
          r_filt <= w_filt_nxt;
          r_cnt  <= w_cnt_nxt;
        end
        r_chg <= ce && (w_y_nxt != w_y);
      end
    end

    assign y[c]   = w_y;
    assign chg[c] = r_chg;
  end

endmodule

// File: tb/tb_ttl_gate_array.sv
// Drives several ttl_gate_array configurations from shared stimulus and checks them
// against a window/history model plus hand-computed expectations.
module tb_ttl_gate_array;
  localparam int N = 11;
  // Instances 0..4: 4 channels x 2 inputs, NOR. Instances 5..10: 1 channel x 3 inputs, FUNC 0..5.
  localparam int P_FILT [5] = '{0, 2, 0, 0, 0};
  localparam int P_DLY  [5] = '{1, 0, 3, 0, 4};
  int M_CH   [N] = '{4, 4, 4, 4, 4, 1, 1, 1, 1, 1, 1};
  int M_IN   [N] = '{2, 2, 2, 2, 2, 3, 3, 3, 3, 3, 3};
  int M_FUNC [N] = '{0, 0, 0, 0, 0, 0, 1, 2, 3, 4, 5};
  int M_FILT [N] = '{0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  int M_DLY  [N] = '{1, 0, 3, 0, 4, 0, 0, 0, 0, 0, 0};

  logic       clk = 1'b0;
  logic       reset;
  logic       ce;
  logic [7:0] a4;
  logic [2:0] a1;
  logic [3:0] dut_y   [N];
  logic [3:0] dut_chg [N];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar i = 0; i < 5; i++) begin : g4
    logic [3:0] yy, cc;
    ttl_gate_array #(.CHANNELS(4), .INPUTS(2), .FUNC(0), .FILTER(P_FILT[i]), .DELAY(P_DLY[i])) dut (
      .clk(clk), .reset(reset), .ce(ce), .a(a4), .y(yy), .chg(cc));
    assign dut_y[i]   = yy;
    assign dut_chg[i] = cc;
  end

  for (genvar j = 0; j < 6; j++) begin : g1
    logic [0:0] yy, cc;
    ttl_gate_array #(.CHANNELS(1), .INPUTS(3), .FUNC(j), .FILTER(0), .DELAY(0)) dut (
      .clk(clk), .reset(reset), .ce(ce), .a(a1), .y(yy), .chg(cc));
    assign dut_y[5+j]   = {3'b000, yy};
    assign dut_chg[5+j] = {3'b000, cc};
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic gate_f(input int func, input int n, input logic [7:0] bits);
    int ones = 0;
    for (int k = 0; k < n; k++) ones += int'(bits[k]);
    case (func)
      0:       return ones == 0;
      1:       return ones != 0;
      2:       return ones != n;
      3:       return ones == n;
      4:       return (ones % 2) == 1;
      default: return (ones % 2) == 0;
    endcase
  endfunction

  // Model: recent f samples, filtered-value history (index 0 = now), expected y/chg.
  logic fw [N][4][16];
  logic fh [N][4][16];
  logic ey [N][4];
  logic ec [N][4];
  int   nsamp [N];
  logic started = 1'b0;
  logic       m_fv, m_nf, m_ny, m_same, m_rv;
  logic [7:0] m_bits;

  always @(posedge clk) begin
    if (reset) begin
      started = 1'b1;
      for (int i = 0; i < N; i++) begin
        nsamp[i] = 0;
        m_rv = gate_f(M_FUNC[i], M_IN[i], 8'h00);
        for (int c = 0; c < 4; c++) begin
          for (int k = 0; k < 16; k++) begin
            fh[i][c][k] = m_rv;
            fw[i][c][k] = m_rv;
          end
          ey[i][c] = m_rv;
          ec[i][c] = 1'b0;
        end
      end
    end else if (ce) begin
      for (int i = 0; i < N; i++) begin
        if (nsamp[i] < 1000) nsamp[i]++;
        for (int c = 0; c < M_CH[i]; c++) begin
          m_bits = (i < 5) ? {6'b0, a4[c*2 +: 2]} : {5'b0, a1};
          m_fv = gate_f(M_FUNC[i], M_IN[i], m_bits);
          for (int k = 15; k > 0; k--) fw[i][c][k] = fw[i][c][k-1];
          fw[i][c][0] = m_fv;
          m_same = 1'b1;
          for (int k = 0; k <= M_FILT[i]; k++) if (fw[i][c][k] != m_fv) m_same = 1'b0;
          m_nf = fh[i][c][0];
          if (nsamp[i] >= M_FILT[i] + 1 && m_same && m_fv != fh[i][c][0]) m_nf = m_fv;
          for (int k = 15; k > 0; k--) fh[i][c][k] = fh[i][c][k-1];
          fh[i][c][0] = m_nf;
          m_ny = fh[i][c][M_DLY[i]];
          ec[i][c] = (m_ny != ey[i][c]);
          ey[i][c] = m_ny;
        end
      end
    end else begin
      for (int i = 0; i < N; i++)
        for (int c = 0; c < 4; c++) ec[i][c] = 1'b0;
    end
  end

  logic [3:0] cmp_y, cmp_c;
  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < N; i++) begin
        cmp_y = '0;
        cmp_c = '0;
        for (int c = 0; c < M_CH[i]; c++) begin
          cmp_y[c] = ey[i][c];
          cmp_c[c] = ec[i][c];
        end
        chk($sformatf("model_y_u%0d", i), 32'(dut_y[i]), 32'(cmp_y));
        chk($sformatf("model_chg_u%0d", i), 32'(dut_chg[i]), 32'(cmp_c));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  localparam int LAT [4] = '{1, 2, 3, 0};
  logic [7:0] tt [6] = '{8'b00000001, 8'b11111110, 8'b01111111,
                         8'b10000000, 8'b10010110, 8'b01101001};
  logic [5:0] rv_lit = 6'b100101;

  initial begin
    reset = 1'b1; ce = 1'b1; a4 = 8'hFF; a1 = 3'b000;
    step(); step();
    chk("rst_y", 32'(dut_y[0]), 32'hF);
    chk("rst_chg", 32'(dut_chg[0]), 32'h0);
    for (int j = 0; j < 6; j++) chk($sformatf("rst_val_func%0d", j), 32'(dut_y[5+j]), 32'(rv_lit[j]));
    reset = 1'b0;
    step();
    chk("rel1_y", 32'(dut_y[0]), 32'hF);
    chk("rel1_chg", 32'(dut_chg[0]), 32'h0);
    step();
    chk("rel2_y", 32'(dut_y[0]), 32'h0);
    chk("rel2_chg", 32'(dut_chg[0]), 32'hF);
    step();
    chk("rel3_chg", 32'(dut_chg[0]), 32'h0);

    // Latency per configuration after a[0] rises.
    a4 = 8'h00;
    repeat (10) step();
    a4 = 8'h01;
    for (int k = 0; k < 6; k++) begin
      step();
      for (int t = 0; t < 4; t++) begin
        chk($sformatf("lat_y_u%0d_k%0d", t, k), 32'(dut_y[t]), (k >= LAT[t]) ? 32'hE : 32'hF);
        chk($sformatf("lat_chg_u%0d_k%0d", t, k), 32'(dut_chg[t]), (k == LAT[t]) ? 32'h1 : 32'h0);
      end
    end

    // Glitch rejection on the FILTER=2 instance.
    a4 = 8'h00;
    repeat (10) step();
    for (int w = 1; w <= 2; w++) begin
      a4 = 8'h01;
      for (int k = 0; k < w + 6; k++) begin
        step();
        if (k == w - 1) a4 = 8'h00;
        chk($sformatf("rej%0d_y", w), 32'(dut_y[1]), 32'hF);
        chk($sformatf("rej%0d_chg", w), 32'(dut_chg[1]), 32'h0);
      end
    end
    a4 = 8'h01;
    for (int k = 0; k < 8; k++) begin
      step();
      if (k == 2) a4 = 8'h00;
      chk($sformatf("acc_y_k%0d", k), 32'(dut_y[1]), (k >= 2 && k <= 4) ? 32'hE : 32'hF);
      chk($sformatf("acc_chg_k%0d", k), 32'(dut_chg[1]), (k == 2 || k == 5) ? 32'h1 : 32'h0);
    end

    // Clock-enable freeze.
    a4 = 8'h00;
    repeat (10) step();
    a4 = 8'h01;
    step();
    chk("ce_n_y", 32'(dut_y[0]), 32'hF);
    ce = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("ce_off_y", 32'(dut_y[0]), 32'hF);
      chk("ce_off_chg", 32'(dut_chg[0]), 32'h0);
    end
    ce = 1'b1;
    step();
    chk("ce_on_y", 32'(dut_y[0]), 32'hE);
    chk("ce_on_chg", 32'(dut_chg[0]), 32'h1);

    // Truth-table walk for every function.
    for (int v = 0; v < 8; v++) begin
      a1 = 3'(v);
      step();
      for (int j = 0; j < 6; j++)
        chk($sformatf("tt_func%0d_a%0d", j, v), 32'(dut_y[5+j]), 32'(tt[j][v]));
    end

    // Reset while a transition is in the DELAY=4 line.
    a4 = 8'h00;
    repeat (10) step();
    a4 = 8'h01;
    step(); step();
    reset = 1'b1;
    a4 = 8'h00;
    step();
    chk("midrst_y", 32'(dut_y[4]), 32'hF);
    chk("midrst_chg", 32'(dut_chg[4]), 32'h0);
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("postrst_y", 32'(dut_y[4]), 32'hF);
      chk("postrst_chg", 32'(dut_chg[4]), 32'h0);
    end

    // Random traffic against the model.
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(2) == 0) a4 = 8'($urandom);
      if ($urandom_range(2) == 0) a1 = 3'($urandom);
      ce    = ($urandom_range(4) != 0);
      reset = ($urandom_range(99) == 0);
      step();
    end
    reset = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/ttl_gate_array.md
# ttl_gate_array

Parametrised, clocked successor to the single quad-NOR package model: CHANNELS independent gates of INPUTS inputs each, with a selectable logic function. Each channel has a synchronous inertial glitch filter and a transport propagation-delay line, both counted in `ce`-qualified master-clock cycles. Discrete-logic board recreations drop it in wherever a gate package's timing or glitch behaviour matters to the circuit.

## Interface
Parameters:
- CHANNELS, 4: number of independent gates (≥1).
- INPUTS, 2: inputs per gate (1..8).
- FUNC, 0: gate function. 0 NOR, 1 OR, 2 NAND, 3 AND, 4 XOR, 5 XNOR. Any other value is an elaboration error.
- FILTER, 0: inertial filter length (0..15). A new value must persist FILTER+1 enabled cycles to pass.
- DELAY, 1: transport delay in enabled cycles after the filter (0..15).

Ports:
- clk  in  1  master clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- ce  in  1  clock enable. State advances only on edges where ce=1.
- a  in  CHANNELS*INPUTS  gate inputs. Bit c*INPUTS+k is input k of channel c.
- y  out  CHANNELS  gate outputs, registered.
- chg  out  CHANNELS  one-cycle strobe. chg[c]=1 in the first cycle y[c] shows a new value.

## Operation
- RST_VAL is FUNC evaluated with all inputs 0: NOR=1, OR=0, NAND=1, AND=0, XOR=0, XNOR=1.
- Per channel, three stages:
  - f[c]: combinational FUNC of the channel's INPUTS bits. XOR/XNOR is parity over all INPUTS bits.
  - Filter: register filt[c] and counter cnt[c], width max(1, clog2(FILTER+1)). On each enabled edge:
    - if f==filt: cnt<=0.
    - else if cnt==FILTER: filt<=f, cnt<=0.
    - else: cnt<=cnt+1.
  - Delay line: DELAY-stage shift register fed by filt. y is the last stage. When DELAY=0, y is filt directly, which is still registered.
- chg: on every clk edge, chg[c] <= (ce && y_next[c]!=y[c]). It is 0 on edges with ce=0 and on reset edges.
- Reset has priority over ce. On any edge with reset=1:
  - filt, every delay stage and y load RST_VAL.
  - cnt and chg clear to 0.
  - Pending transitions are discarded.
- Channels are fully independent; no cross-channel state.

## Timing
- Reset values: y=RST_VAL on all channels, chg=0.
- Latency from an input change that is held steady to the matching y change is 1+FILTER+DELAY enabled edges. Minimum 1 (FILTER=0, DELAY=0).
- Pulse rejection: an f excursion shorter than FILTER+1 consecutive enabled samples never reaches filt. cnt returns to 0 the first enabled edge f matches filt again.
- An accepted pulse of N enabled cycles (N≥FILTER+1) appears on y as a pulse of N enabled cycles. The width is preserved and the pulse is shifted by the latency.
- ce=0 cycles freeze filt, cnt and the delay line. Latency stretches by exactly the number of disabled cycles.
- Inputs change before reset releases: f is sampled on the first enabled edge with reset=0.
- chg never asserts for two consecutive cycles unless y toggles on two consecutive enabled edges, which requires FILTER=0.

## Test plan
- Reset (defaults). Drive a=8'hFF and hold reset 2 cycles: y=4'hF, chg=0. Release with ce=1: y=4'h0 on the 2nd edge after release, and chg=4'hF for exactly that one cycle.
- Latency (defaults). From a=0 (y=4'hF), set a[0]=1 before edge n: y[0]=0 after edge n+1, chg=4'b0001 for one cycle, y[3:1] unchanged. Repeat with DELAY=0 (change after edge n) and DELAY=3 (after edge n+3).
- Filter (FILTER=2, DELAY=0). Pulse a[0] high for 1 and then 2 cycles: y[0] stays 1 and chg stays 0. Pulse it for 3 cycles: y[0]=0 from edge n+2 for exactly 3 cycles, and chg pulses on both transitions.
- ce gating (defaults). Set a[0]=1, then drop ce for 5 cycles after the first edge: y[0] frozen at 1 and chg=0 throughout. y[0] falls on the first enabled edge after ce returns, 7 cycles after the input change.
- Function sweep (CHANNELS=1, INPUTS=3, DELAY=0; each FUNC 0..5). Walk a through 0..7: y matches the truth table one edge later. For example, XOR gives y=1 for a=3'b001, 3'b111 and y=0 for 3'b011. Check RST_VAL per FUNC.
- Reset mid-flight (DELAY=4). Change a[0] to 1, then assert reset 2 edges later: y[0]=RST_VAL=1 after the reset edge. Hold a[0]=0 after reset: y[0] never falls and chg stays 0.
